// File: rtl/ind_seq_ctrl_if.sv
// Command channel of the indicator sequencer: valid/ready handshake plus
// the operands that are sampled when a command is accepted.
interface ind_seq_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_arg;
  logic [DIV_W-1:0] div;
  logic [LEN_W-1:0] len;
  logic             dir;

  modport master (output cmd_valid, cmd_op, cmd_arg, div, len, dir,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_arg, div, len, dir,
                  output cmd_ready);
endinterface

// File: rtl/ind_seq_ctrl.sv
// Indicator sequencer: walks a 3-bit index through the fixed pattern table
// at a prescaled rate, under STOP/RUN/STEP/LOAD commands.
module ind_seq_ctrl #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  ind_seq_ctrl_if.slave cmd,
  output logic          busy,
  output logic          done,
  output logic          cmd_err,
  output logic [2:0]    ind_idx,
  output logic [2:0]    ind_out
);

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT} state_t;

  // operands captured at command accept; immune to later input changes
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [LEN_W-1:0] len;
    logic             dir;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q;
  logic [DIV_W-1:0] presc_q;
  logic [LEN_W-1:0] rem_q;
  logic             rdy, acc, tick, last, done_d;

  // handshake and step-timing decode
  always_comb begin
    rdy    = (state_q != STEP_WAIT);
    acc    = cmd.cmd_valid & rdy;
    tick   = (state_q != IDLE) && (presc_q == '0);
    // final step of a bounded run; len==0 means continuous
    last   = (state_q == RUN) && tick && (cfg_q.len != '0) && (rem_q == LEN_W'(1));
    done_d = last || ((state_q == STEP_WAIT) && tick);
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc && cmd.cmd_op == OP_RUN)       state_d = RUN;
        else if (acc && cmd.cmd_op == OP_STEP) state_d = STEP_WAIT;
      end
      RUN: begin
        if (last || (acc && cmd.cmd_op == OP_STOP)) state_d = IDLE;
      end
      STEP_WAIT: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy          = (state_q != IDLE);
    cmd.cmd_ready = rdy;
  end

  // datapath: prescaler, remaining count, index, status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q   <= '0;
      presc_q <= '0;
      rem_q   <= '0;
      ind_idx <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      done    <= done_d;
      // anything but STOP during a run is dropped and flagged
      cmd_err <= (state_q == RUN) && acc && (cmd.cmd_op != OP_STOP);
      if (state_q == IDLE) begin
        if (acc) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              cfg_q   <= '{div: cmd.div, len: cmd.len, dir: cmd.dir};
              presc_q <= cmd.div;
              rem_q   <= cmd.len;
            end
            OP_STEP: begin
              cfg_q.div <= cmd.div;
              cfg_q.dir <= cmd.dir;
              presc_q   <= cmd.div;
            end
            OP_LOAD: ind_idx <= cmd.cmd_arg;
            default: ;
          endcase
        end
      end else if (tick) begin
        // a tick is applied even when STOP is accepted on the same edge
        presc_q <= cfg_q.div;
        ind_idx <= cfg_q.dir ? ind_idx - 3'd1 : ind_idx + 3'd1;
        if (state_q == RUN && cfg_q.len != '0) rem_q <= rem_q - LEN_W'(1);
      end else begin
        presc_q <= presc_q - DIV_W'(1);
      end
    end
  end

  // pattern table lookup
  always_comb begin
    case (ind_idx)
      3'd0:    ind_out = 3'b000;
      3'd1:    ind_out = 3'b011;
      3'd2:    ind_out = 3'b010;
      3'd3:    ind_out = 3'b101;
      3'd4:    ind_out = 3'b001;
      3'd5:    ind_out = 3'b110;
      3'd6:    ind_out = 3'b100;
      default: ind_out = 3'b111;
    endcase
  end

endmodule

// File: tb/tb_ind_seq_ctrl.sv
// Directed bench for ind_seq_ctrl: hand-computed index/pattern sequences.
module tb_ind_seq_ctrl;
  localparam int DIV_W = 16;
  localparam int LEN_W = 8;
  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy, done, cmd_err;
  logic [2:0] ind_idx, ind_out;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] pat [8] = '{3'b000, 3'b011, 3'b010, 3'b101, 3'b001, 3'b110, 3'b100, 3'b111};

  always #5 clk = ~clk;

  ind_seq_ctrl_if #(.DIV_W(DIV_W), .LEN_W(LEN_W)) cif ();

  ind_seq_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cif),
    .busy    (busy),
    .done    (done),
    .cmd_err (cmd_err),
    .ind_idx (ind_idx),
    .ind_out (ind_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] arg,
                      input int d, input int l, input logic dr);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    cif.div       = DIV_W'(d);
    cif.len       = LEN_W'(l);
    cif.dir       = dr;
    cyc();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_arg   = '0;
    cif.div       = '0;
    cif.len       = '0;
    cif.dir       = 1'b0;

    // reset state
    repeat (2) cyc();
    chk("rst_idx", ind_idx, 0);
    chk("rst_out", ind_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    rst = 1'b1;
    cyc();

    // 1: async reset in the middle of a continuous run
    send(OP_RUN, 3'd0, 0, 0, 1'b0);
    repeat (3) cyc();
    chk("t1_pre_idx", ind_idx, 3);
    chk("t1_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_idx", ind_idx, 0);
    chk("t1_out", ind_out, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    #1 rst = 1'b1;
    cyc();
    chk("t1_ready", cif.cmd_ready, 1);
    chk("t1_idle_idx", ind_idx, 0);

    // 2: bounded run div=2 len=3 up; inputs change after accept
    send(OP_RUN, 3'd0, 2, 3, 1'b0);
    cif.div = 16'd7;
    cif.len = 8'd0;
    cif.dir = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("t2_idx", ind_idx, k / 3);
      chk("t2_out", ind_out, pat[k / 3]);
      chk("t2_done", done, (k == 9) ? 1 : 0);
    end
    chk("t2_busy", busy, 0);
    cyc();
    chk("t2_done_end", done, 0);

    // 3: load then down run div=0 len=3
    send(OP_LOAD, 3'd1, 0, 0, 1'b0);
    chk("t3_load_idx", ind_idx, 1);
    chk("t3_load_done", done, 0);
    send(OP_RUN, 3'd0, 0, 3, 1'b1);
    chk("t3_idx0", ind_idx, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      e = (1 - k) & 7;
      chk("t3_idx", ind_idx, e);
      chk("t3_out", ind_out, pat[e]);
      chk("t3_done", done, (k == 3) ? 1 : 0);
    end
    chk("t3_busy", busy, 0);

    // 4: continuous run div=1 from 6, wraps, STOP at 5
    send(OP_RUN, 3'd0, 1, 0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      cyc();
      e = (6 + k / 2) % 8;
      chk("t4_idx", ind_idx, e);
      chk("t4_out", ind_out, pat[e]);
      chk("t4_busy", busy, 1);
    end
    send(OP_STOP, 3'd0, 0, 0, 1'b0);
    chk("t4_stop_idx", ind_idx, 5);
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_done", done, 0);
    cyc();
    chk("t4_hold_idx", ind_idx, 5);
    chk("t4_hold_done", done, 0);

    // 5: single step div=4
    send(OP_STEP, 3'd0, 4, 0, 1'b0);
    chk("t5_ready0", cif.cmd_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t5_ready", cif.cmd_ready, 0);
      chk("t5_wait_idx", ind_idx, 5);
    end
    cyc();
    chk("t5_idx", ind_idx, 6);
    chk("t5_done", done, 1);
    chk("t5_ready_end", cif.cmd_ready, 1);
    chk("t5_busy", busy, 0);
    cyc();
    chk("t5_done_end", done, 0);

    // 6: LOAD during run is dropped; STOP on the final tick
    send(OP_RUN, 3'd0, 1, 2, 1'b0);
    send(OP_LOAD, 3'd6, 0, 0, 1'b0);
    chk("t6_err", cmd_err, 1);
    chk("t6_idx_a", ind_idx, 6);
    cyc();
    chk("t6_idx_b", ind_idx, 7);
    chk("t6_err_end", cmd_err, 0);
    cyc();
    chk("t6_idx_c", ind_idx, 7);
    send(OP_STOP, 3'd0, 0, 0, 1'b0);
    chk("t6_idx_d", ind_idx, 0);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    cyc();
    chk("t6_done_end", done, 0);
    chk("t6_idle_idx", ind_idx, 0);

    // 7: single down step div=0 wraps 0 -> 7
    send(OP_STEP, 3'd0, 0, 0, 1'b1);
    chk("t7_ready0", cif.cmd_ready, 0);
    cyc();
    chk("t7_idx", ind_idx, 7);
    chk("t7_out", ind_out, 3'b111);
    chk("t7_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
